// File: rtl/tiny_nn_pool_engine.sv
// Streaming FP16 pooling engine: folds channel-interleaved samples into one max/min per channel
// per window, buffers one result set and drains it as byte or half-word beats.
module tiny_nn_pool_engine #(
  parameter int Channels   = 4,
  parameter int CountWidth = 8,
  parameter int OutWidth   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [CountWidth-1:0] window_i,
  input  logic                  mode_i,
  input  logic                  relu_i,
  output logic                  busy_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [15:0]           in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [OutWidth-1:0]   out_data_o,
  output logic                  out_last_o
);
  localparam int ChW = (Channels > 1) ? $clog2(Channels) : 1;
  localparam logic [ChW-1:0] LastCh = ChW'(Channels - 1);
  localparam logic [15:0] FPStdNaN = 16'h7e00;
  localparam logic [15:0] FPNegInf = 16'hfc00;
  localparam logic [15:0] FPPosInf = 16'h7c00;
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  // a > b in FP16; any NaN compares false and +0 equals -0
  function automatic logic fp_cmp_gt(input logic [15:0] a, input logic [15:0] b);
    logic res;
    if (((a[14:10] == 5'h1f) && (a[9:0] != 10'h0)) || ((b[14:10] == 5'h1f) && (b[9:0] != 10'h0)))
      res = 1'b0;
    else if ((a[14:0] == 15'h0) && (b[14:0] == 15'h0))
      res = 1'b0;
    else if (a[15] != b[15])
      res = b[15];
    else if (!a[15])
      res = a[14:0] > b[14:0];
    else
      res = a[14:0] < b[14:0];
    return res;
  endfunction

  logic [1:0]            state_reg, state_next;
  logic [CountWidth-1:0] window_reg, cnt_reg;
  logic                  mode_reg, relu_reg;
  logic [ChW-1:0]        ch_reg, drain_ch_reg;
  logic                  pending_reg, drain_half_reg;
  logic [15:0]           buf_word [Channels];
  logic [15:0]           drain_word;

  logic at_window_end, in_fire, term_fire, sample_fire, start_fire;
  logic have_samples, commit, last_beat, beat_fire;

  assign have_samples  = (ch_reg != '0) || (cnt_reg != CountWidth'(1));
  assign at_window_end = (ch_reg == LastCh) && (cnt_reg == window_reg);
  assign in_ready_o    = (state_reg == StRun) && !(pending_reg && at_window_end);
  assign in_fire       = in_valid_i && in_ready_o;
  assign term_fire     = in_fire && (in_data_i == FPStdNaN);
  assign sample_fire   = in_fire && (in_data_i != FPStdNaN);
  assign start_fire    = (state_reg == StIdle) && start_i && (window_i != '0);
  // Partial window is only flushed once the buffer is empty.
  assign commit        = (sample_fire && at_window_end) ||
                         ((state_reg == StFlush) && have_samples && !pending_reg);
  assign last_beat     = (drain_ch_reg == LastCh) && ((OutWidth == 16) || drain_half_reg);
  assign beat_fire     = pending_reg && out_ready_i;

  assign busy_o      = (state_reg != StIdle);
  assign out_valid_o = pending_reg;
  assign out_last_o  = pending_reg && last_beat;

  for (genvar gi = 0; gi < Channels; gi++) begin : g_ch
    logic [15:0] acc_reg, buf_reg, fold_val, commit_val;
    logic        hit;

    // NaN samples never win a comparison, so they cannot enter the accumulator.
    assign hit = sample_fire && (ch_reg == ChW'(gi)) &&
                 (mode_reg ? fp_cmp_gt(acc_reg, in_data_i) : fp_cmp_gt(in_data_i, acc_reg));
    assign fold_val   = hit ? in_data_i : acc_reg;
    assign commit_val = (relu_reg && fold_val[15]) ? 16'h0000 : fold_val;
    assign buf_word[gi] = buf_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        acc_reg <= FPNegInf;
        buf_reg <= '0;
      end else begin
        if (start_fire)
          acc_reg <= mode_i ? FPPosInf : FPNegInf;
        else if (commit)
          acc_reg <= mode_reg ? FPPosInf : FPNegInf;
        else
          acc_reg <= fold_val;
        if (commit)
          buf_reg <= commit_val;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      StIdle:  if (start_fire) state_next = StRun;
      StRun:   if (term_fire) state_next = StFlush;
      StFlush: if (!have_samples && (!pending_reg || (beat_fire && last_beat)))
                 state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= StIdle;
      window_reg     <= '0;
      mode_reg       <= 1'b0;
      relu_reg       <= 1'b0;
      ch_reg         <= '0;
      cnt_reg        <= CountWidth'(1);
      pending_reg    <= 1'b0;
      drain_ch_reg   <= '0;
      drain_half_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_fire) begin
        window_reg <= window_i;
        mode_reg   <= mode_i;
        relu_reg   <= relu_i;
      end
      if (start_fire || commit) begin
        ch_reg  <= '0;
        cnt_reg <= CountWidth'(1);
      end else if (sample_fire) begin
        if (ch_reg == LastCh) begin
          ch_reg  <= '0;
          cnt_reg <= cnt_reg + 1'b1;
        end else begin
          ch_reg <= ch_reg + 1'b1;
        end
      end
      if (commit)
        pending_reg <= 1'b1;
      else if (beat_fire && last_beat)
        pending_reg <= 1'b0;
      if (beat_fire) begin
        if ((OutWidth == 16) || drain_half_reg) begin
          drain_half_reg <= 1'b0;
          drain_ch_reg   <= last_beat ? '0 : drain_ch_reg + 1'b1;
        end else begin
          drain_half_reg <= 1'b1;
        end
      end
    end
  end

  assign drain_word = buf_word[drain_ch_reg];

  if (OutWidth == 16) begin : g_out16
    assign out_data_o = pending_reg ? drain_word : '0;
  end else begin : g_out8
    assign out_data_o = pending_reg ? (drain_half_reg ? drain_word[15:8] : drain_word[7:0]) : '0;
  end

endmodule

// File: tb/tb_tiny_nn_pool_engine.sv
// Directed bench for tiny_nn_pool_engine: three instances (1ch/8b, 2ch/8b, 2ch/16b) driven from
// a vector table plus hand sequences for backpressure, window 0 and reset mid-drain.
module tb_tiny_nn_pool_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start     [3];
  logic [7:0]  window    [3];
  logic        mode      [3];
  logic        relu      [3];
  logic        in_valid  [3];
  logic [15:0] in_data   [3];
  logic        out_ready [3];
  logic        busy      [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_last  [3];
  logic [15:0] out_data  [3];
  logic [7:0]  od0, od1;
  logic [15:0] od2;

  assign out_data[0] = {8'h00, od0};
  assign out_data[1] = {8'h00, od1};
  assign out_data[2] = od2;

  tiny_nn_pool_engine #(.Channels(1), .CountWidth(8), .OutWidth(8)) dut_c1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .window_i(window[0]), .mode_i(mode[0]),
    .relu_i(relu[0]), .busy_o(busy[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_data_i(in_data[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_data_o(od0), .out_last_o(out_last[0]));

  tiny_nn_pool_engine #(.Channels(2), .CountWidth(8), .OutWidth(8)) dut_c2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .window_i(window[1]), .mode_i(mode[1]),
    .relu_i(relu[1]), .busy_o(busy[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_data_i(in_data[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_data_o(od1), .out_last_o(out_last[1]));

  tiny_nn_pool_engine #(.Channels(2), .CountWidth(8), .OutWidth(16)) dut_w16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .window_i(window[2]), .mode_i(mode[2]),
    .relu_i(relu[2]), .busy_o(busy[2]), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .in_data_i(in_data[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
    .out_data_o(od2), .out_last_o(out_last[2]));

  typedef struct {
    int               k;
    logic             mode;
    logic             relu;
    logic [7:0]       window;
    int               ns;
    logic [0:9][15:0] smp;
    int               nb;
    logic [0:7][15:0] beat;
    logic [0:7]       last;
  } vec_t;

  vec_t vecs [8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, " flags"}, {12'h0, busy[k], in_ready[k], out_valid[k], out_last[k]}, 16'h0);
    check({tag, " data"}, out_data[k], 16'h0);
  endtask

  task automatic start_op(input int k, input logic [7:0] w, input logic m, input logic r);
    @(negedge clk);
    start[k] = 1'b1; window[k] = w; mode[k] = m; relu[k] = r;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [15:0] d, input string tag);
    int guard = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    while (!in_ready[k] && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready[k]) begin
      n_checks++; n_fail++;
      $display("FAIL %s: in_ready never rose, got 0, expected 1", tag);
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic collect(input int k, input int n, input logic [0:7][15:0] exp_d,
                         input logic [0:7] exp_l, input string tag);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 2000) begin
      if (out_valid[k] && out_ready[k]) begin
        check($sformatf("%s beat%0d data", tag, got), out_data[k], exp_d[got]);
        check($sformatf("%s beat%0d last", tag, got), {15'h0, out_last[k]}, {15'h0, exp_l[got]});
        got++;
      end
      @(negedge clk);
      guard++;
    end
    if (got < n) begin
      n_checks++; n_fail++;
      $display("FAIL %s beat count: got %0d, expected %0d", tag, got, n);
    end
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1'b0, 8'd4, 5,
                {16'h3c00, 16'hbc00, 16'h4000, 16'h3800, 16'h7e00, {5{16'h0000}}},
                2, {16'h0000, 16'h0040, {6{16'h0000}}}, 8'b0100_0000};
    vecs[1] = '{1, 1'b1, 1'b0, 8'd2, 5,
                {16'h4000, 16'hc000, 16'h3c00, 16'h4400, 16'h7e00, {5{16'h0000}}},
                4, {16'h0000, 16'h003c, 16'h0000, 16'h00c0, {4{16'h0000}}}, 8'b0001_0000};
    vecs[2] = '{1, 1'b0, 1'b1, 8'd2, 5,
                {16'h4000, 16'hc000, 16'h3c00, 16'hbc00, 16'h7e00, {5{16'h0000}}},
                4, {16'h0000, 16'h0040, 16'h0000, 16'h0000, {4{16'h0000}}}, 8'b0001_0000};
    vecs[3] = '{1, 1'b0, 1'b0, 8'd2, 5,
                {16'h3800, 16'h3c00, 16'h7c01, 16'h4200, 16'h7e00, {5{16'h0000}}},
                4, {16'h0000, 16'h0038, 16'h0000, 16'h0042, {4{16'h0000}}}, 8'b0001_0000};
    vecs[4] = '{2, 1'b0, 1'b0, 8'd1, 5,
                {16'hc400, 16'h8000, 16'h0000, 16'h3555, 16'h7e00, {5{16'h0000}}},
                4, {16'hc400, 16'h8000, 16'h0000, 16'h3555, {4{16'h0000}}}, 8'b0101_0000};
    vecs[5] = '{1, 1'b0, 1'b0, 8'd2, 2,
                {16'h3c00, 16'h7e00, {8{16'h0000}}},
                4, {16'h0000, 16'h003c, 16'h0000, 16'h00fc, {4{16'h0000}}}, 8'b0001_0000};
    vecs[6] = '{0, 1'b1, 1'b0, 8'd3, 4,
                {16'h3c00, 16'hfc00, 16'h0000, 16'h7e00, {6{16'h0000}}},
                2, {16'h0000, 16'h00fc, {6{16'h0000}}}, 8'b0100_0000};
    vecs[7] = '{1, 1'b0, 1'b0, 8'd2, 5,
                {16'h8000, 16'h4000, 16'h0000, 16'h4000, 16'h7e00, {5{16'h0000}}},
                4, {16'h0000, 16'h0080, 16'h0000, 16'h0040, {4{16'h0000}}}, 8'b0001_0000};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; window[k] = 8'h0; mode[k] = 1'b0; relu[k] = 1'b0;
      in_valid[k] = 1'b0; in_data[k] = 16'h0; out_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_idle(k, $sformatf("reset dut%0d", k));
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      int k;
      k = vecs[v].k;
      start_op(k, vecs[v].window, vecs[v].mode, vecs[v].relu);
      check($sformatf("v%0d busy_after_start", v), {15'h0, busy[k]}, 16'h1);
      check($sformatf("v%0d ready_after_start", v), {15'h0, in_ready[k]}, 16'h1);
      out_ready[k] = 1'b1;
      fork
        begin
          for (int i = 0; i < vecs[v].ns; i++) send(k, vecs[v].smp[i], $sformatf("v%0d smp%0d", v, i));
        end
        collect(k, vecs[v].nb, vecs[v].beat, vecs[v].last, $sformatf("v%0d", v));
      join
      check($sformatf("v%0d busy_after_drain", v), {15'h0, busy[k]}, 16'h0);
      $display("vector %0d: dut%0d window=%0d mode=%0d relu=%0d, %0d samples, %0d beats",
               v, k, vecs[v].window, vecs[v].mode, vecs[v].relu, vecs[v].ns, vecs[v].nb);
    end

    start_op(1, 8'd0, 1'b0, 1'b0);
    check("window0 busy", {15'h0, busy[1]}, 16'h0);
    check("window0 ready", {15'h0, in_ready[1]}, 16'h0);
    $display("window 0 start: dut1 busy=%0d", busy[1]);

    start_op(1, 8'd1, 1'b0, 1'b0);
    out_ready[1] = 1'b0;
    send(1, 16'h3c01, "bp a");
    check("bp ready_mid_window", {15'h0, in_ready[1]}, 16'h1);
    send(1, 16'h4000, "bp b");
    check("bp ready_after_commit", {15'h0, in_ready[1]}, 16'h1);
    send(1, 16'hc000, "bp c");
    check("bp ready_drop", {15'h0, in_ready[1]}, 16'h0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp hold%0d", i),
            {out_valid[1], out_last[1], in_ready[1], 5'h0, out_data[1][7:0]}, 16'h8001);
      @(negedge clk);
    end
    out_ready[1] = 1'b1;
    fork
      begin
        send(1, 16'h3800, "bp d");
        send(1, 16'h7e00, "bp term");
      end
      collect(1, 8, {16'h0001, 16'h003c, 16'h0000, 16'h0040, 16'h0000, 16'h00c0, 16'h0000, 16'h0038},
              8'b0001_0001, "bp");
    join
    check("bp busy_after_drain", {15'h0, busy[1]}, 16'h0);
    $display("backpressure sequence: 4 samples, 8 beats");

    start_op(1, 8'd2, 1'b0, 1'b0);
    out_ready[1] = 1'b1;
    fork
      begin
        send(1, 16'h3c00, "rst smp");
        send(1, 16'h7e00, "rst term");
      end
      collect(1, 2, {16'h0000, 16'h003c, {6{16'h0000}}}, 8'b0000_0000, "rst");
    join
    check("rst mid_drain_valid", {15'h0, out_valid[1]}, 16'h1);
    rst_n = 1'b0;
    #1;
    check_idle(1, "rst async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(1, "rst released");
    $display("reset mid-drain: dut1 out_valid=%0d busy=%0d", out_valid[1], busy[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
